// File: rtl/alu_pkg.sv
// Opcode width and encodings shared by the TP1 ALU and its front end.
package alu_pkg;
  localparam int NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
endpackage

// File: rtl/alu.sv
// Combinational TP1 ALU: signed operands, truncated result, signed overflow
// on ADD/SUB only; unknown opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_overflow
);
  localparam int MSB = NB_DATA - 1;

  logic signed [NB_DATA-1:0] a_s;
  logic signed [NB_DATA-1:0] b_s;
  logic signed [NB_DATA-1:0] sum;
  logic signed [NB_DATA-1:0] diff;

  assign a_s  = i_a;
  assign b_s  = i_b;
  assign sum  = a_s + b_s;
  assign diff = a_s - b_s;

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result   = sum;
        o_overflow = (a_s[MSB] == b_s[MSB]) && (sum[MSB] != a_s[MSB]);
      end
      OP_SUB: begin
        o_result   = diff;
        o_overflow = (a_s[MSB] != b_s[MSB]) && (diff[MSB] != a_s[MSB]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRA:  o_result = a_s >>> i_b;
      OP_SRL:  o_result = i_a >> i_b;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, run-length debouncer and rising-edge pulse for one
// raw push-button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_pulse
);
  localparam int NB_CNT = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic              sync_p0;
  logic              sync_p1;
  logic              stable;
  logic              stable_q;
  logic [NB_CNT-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_p0  <= i_button;
      sync_p1  <= sync_p0;
      stable_q <= stable;
      // Any cycle agreeing with the accepted level restarts the run.
      if (sync_p1 != stable) begin
        if (cnt == NB_CNT'(DEBOUNCE_CYCLES - 1)) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_pulse = stable & ~stable_q;
endmodule

// File: rtl/alu_input_ctrl.sv
// Board front end for the TP1 ALU: debounced buttons load A, B and opcode
// from the switches; result and flags are registered behind the ALU.
module alu_input_ctrl #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic [2:0]         i_button,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_negative,
  output logic               o_overflow,
  output logic               o_valid,
  output logic [2:0]         o_loaded
);
  logic [2:0]         pulse;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic [2:0]         loaded_q;
  logic               valid_q;
  logic [NB_DATA-1:0] alu_result;
  logic               alu_overflow;
  logic [NB_DATA-1:0] result_q;
  logic               zero_q;
  logic               neg_q;
  logic               ovf_q;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_button(i_button[i]),
      .o_pulse (pulse[i])
    );
  end

  alu #(
    .NB_DATA(NB_DATA)
  ) u_alu (
    .i_a       (a_q),
    .i_b       (b_q),
    .i_op      (op_q),
    .o_result  (alu_result),
    .o_overflow(alu_overflow)
  );

  // Operand load stage, then result/flag stage one cycle behind it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      loaded_q <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (pulse[0]) a_q  <= i_sw;
      if (pulse[1]) b_q  <= i_sw;
      if (pulse[2]) op_q <= i_sw[NB_OP-1:0];
      loaded_q <= loaded_q | pulse;
      valid_q  <= valid_q | (&loaded_q);
      result_q <= alu_result;
      zero_q   <= (alu_result == '0);
      neg_q    <= alu_result[NB_DATA-1];
      ovf_q    <= alu_overflow;
    end
  end

  assign o_result   = result_q;
  assign o_zero     = zero_q & valid_q;
  assign o_negative = neg_q & valid_q;
  assign o_overflow = ovf_q & valid_q;
  assign o_valid    = valid_q;
  assign o_loaded   = loaded_q;
endmodule

// File: tb/tb_alu_input_ctrl.sv
// Randomised and directed bench for alu_input_ctrl against a window-based
// debounce model and an integer-arithmetic ALU reference.
module tb_alu_input_ctrl;
  localparam int D    = 4;
  localparam int MAXE = 20000;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                         OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                         SRA = 6'b000011, SRL = 6'b000010;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_sw = 8'h00;
  logic [2:0] i_button = 3'b111;
  logic [7:0] o_result;
  logic       o_zero, o_negative, o_overflow, o_valid;
  logic [2:0] o_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  alu_input_ctrl #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_sw      (i_sw),
    .i_button  (i_button),
    .o_result  (o_result),
    .o_zero    (o_zero),
    .o_negative(o_negative),
    .o_overflow(o_overflow),
    .o_valid   (o_valid),
    .o_loaded  (o_loaded)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic.
  task automatic alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         output logic [7:0] res, output logic ovf);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    ovf = 1'b0;
    case (op)
      ADD:  begin r = sa + sb; ovf = (r > 127) || (r < -128); end
      SUB:  begin r = sa - sb; ovf = (r > 127) || (r < -128); end
      AND_: r = int'(a & b);
      OR_:  r = int'(a | b);
      XOR_: r = int'(a ^ b);
      NOR_: r = int'(~(a | b));
      SRA:  r = sa >>> b;
      SRL:  r = int'(a >> b);
      default: r = 0;
    endcase
    res = r[7:0];
  endtask

  // Model state. A button level is accepted once the synchronised samples
  // of the last D edges all differ from the accepted level, with none of
  // those edges at or before the last reset or flip.
  bit         raw_h [3][MAXE];
  bit         rst_h [MAXE];
  int         edge_n = 0;
  int         last_clr [3];
  bit         stab [3];
  bit         rose [3];
  logic [7:0] m_a, m_b, m_res;
  logic [5:0] m_op;
  logic [2:0] m_loaded;
  logic       m_valid, m_ovf;

  function automatic int sval(int b, int idx);
    if (rst_h[idx]) return 2;
    if (idx < 2 || rst_h[idx-1] || rst_h[idx-2]) return 0;
    return int'(raw_h[b][idx-2]);
  endfunction

  initial begin
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_loaded = 0; m_valid = 0; m_ovf = 0;
    for (int b = 0; b < 3; b++) begin stab[b] = 0; rose[b] = 0; last_clr[b] = 0; end
  end

  always @(posedge i_clk) begin
    logic [7:0] r;
    logic       v;
    int         e;
    bit         ok;
    e = edge_n;
    rst_h[e] = i_reset;
    for (int b = 0; b < 3; b++) raw_h[b][e] = i_button[b];
    if (i_reset) begin
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_loaded = 0; m_valid = 0; m_ovf = 0;
      for (int b = 0; b < 3; b++) begin stab[b] = 0; rose[b] = 0; last_clr[b] = e; end
    end else begin
      alu_ref(m_a, m_b, m_op, r, v);
      m_res   = r;
      m_ovf   = v;
      m_valid = m_valid | (&m_loaded);
      if (rose[0]) m_a = i_sw;
      if (rose[1]) m_b = i_sw;
      if (rose[2]) m_op = i_sw[5:0];
      for (int b = 0; b < 3; b++) if (rose[b]) m_loaded[b] = 1'b1;
      for (int b = 0; b < 3; b++) begin
        ok = (e - last_clr[b] >= D);
        for (int k = 0; k < D && ok; k++)
          if (sval(b, e - k) != int'(!stab[b])) ok = 0;
        rose[b] = 0;
        if (ok) begin
          stab[b] = !stab[b];
          last_clr[b] = e;
          rose[b] = stab[b];
        end
      end
    end
    edge_n++;
  end

  task automatic tick();
    logic [14:0] exp_v;
    @(negedge i_clk);
    exp_v = {m_loaded, m_valid, m_valid & (m_res == 8'h00), m_valid & m_res[7],
             m_valid & m_ovf, m_res};
    chk("outputs", {17'd0, o_loaded, o_valid, o_zero, o_negative, o_overflow, o_result},
        {17'd0, exp_v});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [2:0] mask, input logic [7:0] sw);
    i_sw = sw;
    i_button = mask;
    ticks(10);
    i_button = 3'b000;
    ticks(10);
  endtask

  initial begin
    // Buttons held through reset.
    i_sw = 8'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", {o_loaded, o_valid, o_zero, o_negative, o_overflow, o_result}, 15'd0);
    end
    i_reset = 1'b0;
    ticks(6);
    chk("pre_pulse_loaded", o_loaded, 3'b000);
    tick();
    chk("post_pulse_loaded", o_loaded, 3'b111);
    chk("valid_lag", o_valid, 1'b0);
    tick();
    chk("valid_set", o_valid, 1'b1);
    chk("held_reset_result", o_result, 8'h40);
    i_button = 3'b000;
    ticks(10);

    // Bouncing A button, then held; switch change while held is ignored.
    for (int i = 0; i < 10; i++) begin
      i_button[0] = ~i_button[0];
      ticks(2);
    end
    chk("bounce_no_load", o_result, 8'h40);
    i_sw = 8'h2A;
    i_button[0] = 1'b1;
    ticks(10);
    chk("bounce_load", o_result, 8'h4A);
    i_sw = 8'h55;
    ticks(10);
    chk("held_ignored", o_result, 8'h4A);
    i_button = 3'b000;
    ticks(10);

    // ADD overflow.
    press(3'b001, 8'h7F);
    press(3'b010, 8'h01);
    press(3'b100, {2'b00, ADD});
    chk("add_result", o_result, 8'h80);
    chk("add_flags", {o_zero, o_negative, o_overflow, o_valid}, 4'b0111);

    // SUB to zero, then SRA.
    press(3'b001, 8'h05);
    press(3'b010, 8'h05);
    press(3'b100, {2'b00, SUB});
    chk("sub_result", o_result, 8'h00);
    chk("sub_flags", {o_zero, o_overflow}, 2'b10);
    press(3'b001, 8'h80);
    press(3'b010, 8'h02);
    press(3'b100, {2'b00, SRA});
    chk("sra_result", o_result, 8'hE0);
    chk("sra_neg", o_negative, 1'b1);

    // Simultaneous A/B load after reset.
    i_reset = 1'b1; ticks(2); i_reset = 1'b0;
    press(3'b011, 8'h03);
    chk("dual_loaded", o_loaded, 3'b011);
    chk("dual_gated", {o_valid, o_zero, o_negative, o_overflow}, 4'b0000);
    press(3'b100, {2'b00, ADD});
    chk("dual_add", o_result, 8'h06);
    chk("dual_valid", o_valid, 1'b1);

    // Reset mid-debounce: released button discarded, held button reloads.
    i_reset = 1'b1; ticks(2); i_reset = 1'b0; ticks(2);
    i_button = 3'b100; ticks(4);
    i_reset = 1'b1; i_button = 3'b000; ticks(2); i_reset = 1'b0;
    ticks(12);
    chk("midreset_discard", o_loaded, 3'b000);
    i_button = 3'b010; ticks(4);
    i_reset = 1'b1; ticks(2); i_reset = 1'b0;
    ticks(6);
    chk("midreset_held_pre", o_loaded, 3'b000);
    tick();
    chk("midreset_held_load", o_loaded, 3'b010);
    i_button = 3'b000; ticks(10);

    // Random segments checked every cycle against the model.
    for (int s = 0; s < 400; s++) begin
      logic [5:0] ops [8];
      ops = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRA, SRL};
      i_sw = 8'($urandom);
      if ($urandom_range(0, 1) == 1) i_sw[5:0] = ops[$urandom_range(0, 7)];
      i_button = 3'($urandom);
      i_reset = ($urandom_range(0, 39) == 0);
      ticks(i_reset ? $urandom_range(1, 3) : $urandom_range(1, 9));
      i_reset = 1'b0;
    end
    i_button = 3'b000;
    ticks(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
